// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared types and widths for the execute stage
// Purpose: ALU opcode enum, datapath widths and the payload struct held by the
//          EX/MEM skid buffer.
package riscv_pkg;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_XOR = 3'b100,
      ALU_SLL = 3'b101,
      ALU_SRL = 3'b110,
      ALU_SLT = 3'b111
   } alu_op_e;

   typedef struct packed {
      logic [XLEN-1:0]       result;
      logic [XLEN-1:0]       store_data;
      logic                  reg_write;
      logic [REG_ADDR_W-1:0] rd_address;
      logic                  data_mem_write;
      logic [1:0]            wb_select;
   } ex_payload_t;

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational integer ALU
// Purpose: computes one ALU operation on two operands.
// Ports:
//   op     in   alu_op_e   operation select
//   a      in   XLEN       operand A
//   b      in   XLEN       operand B (b[4:0] is the shift amount)
//   result out  XLEN       operation result
module alu_core
   import riscv_pkg::*;
(
   input  alu_op_e         op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic [XLEN-1:0] result
);

   logic [4:0] shamt;
   logic       less_signed;

   assign shamt       = b[4:0];
   assign less_signed = ($signed(a) < $signed(b));

   always_comb begin
      result = '0;
      case (op)
         ALU_ADD: result = a + b;
         ALU_SUB: result = a - b;
         ALU_AND: result = a & b;
         ALU_OR:  result = a | b;
         ALU_XOR: result = a ^ b;
         ALU_SLL: result = a << shamt;
         ALU_SRL: result = a >> shamt;
         ALU_SLT: result = {{(XLEN-1){1'b0}}, less_signed};
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/ex_stage_buffer.sv
// rtl/ex_stage_buffer.sv - execute stage with 2-entry skid buffer toward MEM
// Purpose: computes the ALU result when an ID/EX payload is accepted and holds it,
//          with the control fields, in a main/skid register pair so MEM backpressure
//          never creates a combinational ready path back to decode.
// Ports:
//   clk, reset (sync, active-high), flush (drop all entries)
//   in_valid / in_ready (registered)       upstream handshake
//   alu_input1, alu_input2, alu_control    ALU operands and op
//   data_memory_store, reg_write, rd_address, data_mem_write,
//   alu_or_load_or_pc_plus_four            control/data passed through
//   out_valid / out_ready                  downstream handshake
//   alu_result_out, data_memory_store_out, reg_write_out, rd_address_out,
//   data_mem_write_out, alu_or_load_or_pc_plus_four_out   main entry fields
module ex_stage_buffer
   import riscv_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [XLEN-1:0]       alu_input1,
   input  logic [XLEN-1:0]       alu_input2,
   input  logic [XLEN-1:0]       data_memory_store,
   input  logic [2:0]            alu_control,
   input  logic                  reg_write,
   input  logic [REG_ADDR_W-1:0] rd_address,
   input  logic                  data_mem_write,
   input  logic [1:0]            alu_or_load_or_pc_plus_four,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [XLEN-1:0]       alu_result_out,
   output logic [XLEN-1:0]       data_memory_store_out,
   output logic                  reg_write_out,
   output logic [REG_ADDR_W-1:0] rd_address_out,
   output logic                  data_mem_write_out,
   output logic [1:0]            alu_or_load_or_pc_plus_four_out
);

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_TWO   = 2'd2;

   logic [1:0]      state;
   logic [1:0]      state_next;
   ex_payload_t     main_q;
   ex_payload_t     skid_q;
   ex_payload_t     new_payload;
   logic [XLEN-1:0] alu_result;
   logic            in_fire;
   logic            out_fire;

   alu_core u_alu (
      .op     (alu_op_e'(alu_control)),
      .a      (alu_input1),
      .b      (alu_input2),
      .result (alu_result)
   );

   assign new_payload = '{
      result:         alu_result,
      store_data:     data_memory_store,
      reg_write:      reg_write,
      rd_address:     rd_address,
      data_mem_write: data_mem_write,
      wb_select:      alu_or_load_or_pc_plus_four
   };

   assign out_valid = (state != ST_EMPTY);
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;

   always_comb begin
      state_next = state;
      case (state)
         ST_EMPTY: if (in_fire) state_next = ST_ONE;
         ST_ONE: begin
            if (in_fire && !out_fire)      state_next = ST_TWO;
            else if (!in_fire && out_fire) state_next = ST_EMPTY;
         end
         ST_TWO:   if (out_fire) state_next = ST_ONE;
         default:  state_next = ST_EMPTY;
      endcase
      if (flush) state_next = ST_EMPTY;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_EMPTY;
         in_ready <= 1'b0;
         main_q   <= '0;
         skid_q   <= '0;
      end else begin
         state    <= state_next;
         // Ready is a pure function of the next occupancy, so it never
         // depends combinationally on out_ready.
         in_ready <= (state_next != ST_TWO);
         if (!flush) begin
            case (state)
               ST_EMPTY: if (in_fire) main_q <= new_payload;
               ST_ONE: begin
                  if (in_fire && out_fire) main_q <= new_payload;
                  else if (in_fire)        skid_q <= new_payload;
               end
               ST_TWO:   if (out_fire) main_q <= skid_q;
               default: ;
            endcase
         end
      end
   end

   assign alu_result_out                  = main_q.result;
   assign data_memory_store_out           = main_q.store_data;
   assign rd_address_out                  = main_q.rd_address;
   assign alu_or_load_or_pc_plus_four_out = main_q.wb_select;
   // Stale entries stay in main_q; gate the write enables so MEM never sees them.
   assign reg_write_out                   = main_q.reg_write & out_valid;
   assign data_mem_write_out              = main_q.data_mem_write & out_valid;

endmodule

// File: tb/tb_ex_stage_buffer.sv
// tb/tb_ex_stage_buffer.sv - scoreboard bench for ex_stage_buffer
module tb_ex_stage_buffer;

   typedef struct {
      logic [31:0] res;
      logic [31:0] st;
      logic [8:0]  ctrl;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] alu_input1 = '0;
   logic [31:0] alu_input2 = '0;
   logic [31:0] data_memory_store = '0;
   logic [2:0]  alu_control = '0;
   logic        reg_write = 1'b0;
   logic [4:0]  rd_address = '0;
   logic        data_mem_write = 1'b0;
   logic [1:0]  alu_or_load_or_pc_plus_four = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] alu_result_out;
   logic [31:0] data_memory_store_out;
   logic        reg_write_out;
   logic [4:0]  rd_address_out;
   logic        data_mem_write_out;
   logic [1:0]  alu_or_load_or_pc_plus_four_out;

   int   n_checks = 0;
   int   n_pass = 0;
   int   n_out = 0;
   int   cyc = 0;
   exp_t q[$];

   ex_stage_buffer dut (
      .clk                             (clk),
      .reset                           (reset),
      .flush                           (flush),
      .in_valid                        (in_valid),
      .in_ready                        (in_ready),
      .alu_input1                      (alu_input1),
      .alu_input2                      (alu_input2),
      .data_memory_store               (data_memory_store),
      .alu_control                     (alu_control),
      .reg_write                       (reg_write),
      .rd_address                      (rd_address),
      .data_mem_write                  (data_mem_write),
      .alu_or_load_or_pc_plus_four     (alu_or_load_or_pc_plus_four),
      .out_valid                       (out_valid),
      .out_ready                       (out_ready),
      .alu_result_out                  (alu_result_out),
      .data_memory_store_out           (data_memory_store_out),
      .reg_write_out                   (reg_write_out),
      .rd_address_out                  (rd_address_out),
      .data_mem_write_out              (data_mem_write_out),
      .alu_or_load_or_pc_plus_four_out (alu_or_load_or_pc_plus_four_out)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
      logic [4:0] sh;
      sh = b[4:0];
      case (op)
         3'd0: return a + b;
         3'd1: return a - b;
         3'd2: return a & b;
         3'd3: return a | b;
         3'd4: return a ^ b;
         3'd5: return a << sh;
         3'd6: return a >> sh;
         default: begin
            if (a[31] != b[31]) return {31'd0, a[31]};
            return {31'd0, (a < b)};
         end
      endcase
   endfunction

   // Scoreboard: handshakes are stable between negedge and the next posedge.
   always @(negedge clk) begin
      exp_t e;
      if (reset || flush) begin
         q.delete();
      end else begin
         if (out_valid && out_ready) begin
            n_out++;
            if (q.size() == 0) begin
               check("spurious_out", 1, 0);
            end else begin
               e = q.pop_front();
               check("result", alu_result_out, e.res);
               check("store", data_memory_store_out, e.st);
               check("ctrl", {rd_address_out, reg_write_out, data_mem_write_out,
                              alu_or_load_or_pc_plus_four_out}, e.ctrl);
            end
         end
         if (in_valid && in_ready) begin
            e.res  = model(alu_control, alu_input1, alu_input2);
            e.st   = data_memory_store;
            e.ctrl = {rd_address, reg_write, data_mem_write, alu_or_load_or_pc_plus_four};
            q.push_back(e);
         end
      end
   end

   task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] st, input logic [4:0] rd, input logic rw,
                       input logic dmw, input logic [1:0] sel);
      int waited;
      alu_control = op; alu_input1 = a; alu_input2 = b; data_memory_store = st;
      rd_address = rd; reg_write = rw; data_mem_write = dmw;
      alu_or_load_or_pc_plus_four = sel;
      in_valid = 1'b1;
      waited = 0;
      @(negedge clk);
      while (!in_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (!in_ready) check("send_timeout", 0, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int waited;
      waited = 0;
      while (q.size() != 0 && waited < 100) begin
         @(posedge clk); #1;
         waited++;
      end
      check("drain", q.size(), 0);
   endtask

   initial begin
      int n0;
      int t0;
      // Reset held three cycles with all outputs low
      repeat (3) begin
         @(negedge clk);
         check("reset_outs", {in_ready, out_valid, alu_result_out, reg_write_out,
                              data_mem_write_out, rd_address_out,
                              alu_or_load_or_pc_plus_four_out}, 0);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      check("ready_after_reset", in_ready, 1);
      check("empty_after_reset", out_valid, 0);

      // ADD wrap with one-cycle latency
      out_ready = 1'b1;
      send(3'd0, 32'hFFFF_FFFF, 32'h1, 32'h1234_5678, 5'd3, 1'b1, 1'b0, 2'd1);
      check("add_latency", out_valid, 1);
      check("add_wrap", alu_result_out, 32'h0);
      send(3'd7, 32'h8000_0000, 32'h1, 32'h0, 5'd4, 1'b1, 1'b0, 2'd0);
      check("slt_signed", alu_result_out, 32'h1);
      send(3'd6, 32'h8000_0000, 32'h21, 32'h0, 5'd5, 1'b1, 1'b0, 2'd0);
      check("srl_shamt", alu_result_out, 32'h4000_0000);
      send(3'd1, 32'h0, 32'h1, 32'hA5A5_A5A5, 5'd6, 1'b0, 1'b1, 2'd2);
      check("sub_wrap", alu_result_out, 32'hFFFF_FFFF);
      drain();

      // Sustained throughput: four accepts in four cycles
      t0 = cyc;
      for (int i = 0; i < 4; i++)
         send(3'(i + 2), 32'hF0F0_0F0F + i, 32'h0FF0_00FF, i, 5'(i), 1'b1, 1'b0, 2'(i));
      check("throughput_cycles", cyc - t0, 4);
      drain();

      // Four inputs into a stalled sink
      @(posedge clk); #1;
      out_ready = 1'b0;
      n0 = n_out;
      send(3'd0, 32'd10, 32'd1, 32'd100, 5'd10, 1'b1, 1'b0, 2'd0);
      send(3'd0, 32'd20, 32'd2, 32'd200, 5'd11, 1'b1, 1'b0, 2'd1);
      check("ready_drop_two", in_ready, 0);
      check("valid_stalled", out_valid, 1);
      check("hold_main", alu_result_out, 32'd11);
      fork
         begin
            send(3'd0, 32'd30, 32'd3, 32'd300, 5'd12, 1'b1, 1'b0, 2'd2);
            send(3'd0, 32'd40, 32'd4, 32'd400, 5'd13, 1'b1, 1'b1, 2'd3);
         end
         begin
            repeat (2) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      drain();
      @(posedge clk); #1;
      check("four_emitted", n_out - n0, 4);
      check("idle_valid", out_valid, 0);
      check("gated_writes", {reg_write_out, data_mem_write_out}, 0);

      // Flush in TWO with a pending input
      out_ready = 1'b0;
      n0 = n_out;
      send(3'd3, 32'h1, 32'h2, 32'h0, 5'd1, 1'b1, 1'b1, 2'd0);
      send(3'd3, 32'h4, 32'h8, 32'h0, 5'd2, 1'b1, 1'b1, 2'd0);
      in_valid = 1'b1;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      in_valid = 1'b0;
      check("flush_two_valid", out_valid, 0);
      check("flush_two_ready", in_ready, 1);
      check("flush_gated_writes", {reg_write_out, data_mem_write_out}, 0);
      out_ready = 1'b1;
      repeat (5) @(negedge clk);
      check("flush_two_none", n_out - n0, 0);

      // Flush in ONE drops the input accepted in the same cycle
      @(posedge clk); #1;
      out_ready = 1'b0;
      send(3'd4, 32'hFF, 32'h0F, 32'h0, 5'd7, 1'b1, 1'b0, 2'd0);
      alu_input1 = 32'h55;
      in_valid = 1'b1;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      in_valid = 1'b0;
      check("flush_one_valid", out_valid, 0);
      out_ready = 1'b1;
      repeat (5) @(negedge clk);
      check("flush_one_none", n_out - n0, 0);

      // Reset mid-transfer discards entries
      @(posedge clk); #1;
      out_ready = 1'b0;
      send(3'd2, 32'hFF00, 32'h0FF0, 32'h9, 5'd8, 1'b1, 1'b1, 2'd1);
      send(3'd2, 32'hFF00, 32'hF000, 32'h9, 5'd9, 1'b1, 1'b1, 2'd1);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("reset_mid_outs", {in_ready, out_valid, alu_result_out}, 0);
      @(posedge clk); #1;
      check("reset_mid_ready", in_ready, 1);
      check("reset_mid_valid", out_valid, 0);

      // Random traffic with random backpressure
      n0 = n_out;
      fork
         for (int i = 0; i < 20; i++)
            send(3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
         begin
            for (int c = 0; c < 60; c++) begin
               @(posedge clk);
               #1 out_ready = 1'($urandom_range(0, 1));
            end
            out_ready = 1'b1;
         end
      join
      out_ready = 1'b1;
      drain();
      check("random_count", n_out - n0, 20);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
